// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control tokens, TERC4 code table, alignment states and the 8b decode.
// Pure definitions; no clocked logic lives here.
package tmds_pkg;

    localparam int SYM_W = 10;

    // Index i decodes to {c1,c0} = i.
    localparam logic [SYM_W-1:0] CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    // Index i decodes to TERC4 nibble i.
    localparam logic [SYM_W-1:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    typedef enum logic {SEARCH, LOCKED} tmds_align_state_t;

    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic [3:0] terc4;
        logic       terc4_valid;
    } tmds_sym_t;

    // q[9] undoes the DC-balance inversion, q[8] selects XOR or XNOR chaining.
    function automatic logic [7:0] tmds_decode8(input logic [SYM_W-1:0] q);
        logic [7:0] t;
        logic [7:0] d;
        t    = q[9] ? ~q[7:0] : q[7:0];
        d    = '0;
        d[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_decoder_if.sv
// Deserializer-facing word input and decoded symbol outputs of one TMDS channel.
// One word per clock, no backpressure; master drives raw words, slave returns decode.
interface tmds_decoder_if;
    logic [9:0] raw_i;
    logic       locked_o;
    logic [3:0] offset_o;
    logic       de_o;
    logic [1:0] ctrl_o;
    logic [7:0] data_o;
    logic [3:0] terc4_o;
    logic       terc4_valid_o;

    modport master (
        output raw_i,
        input  locked_o, offset_o, de_o, ctrl_o, data_o, terc4_o, terc4_valid_o
    );

    modport slave (
        input  raw_i,
        output locked_o, offset_o, de_o, ctrl_o, data_o, terc4_o, terc4_valid_o
    );
endinterface

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into control/data/TERC4 views.
// Zero latency, no backpressure; usable for any of the three channels.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output tmds_sym_t        dec
);

    always_comb begin
        dec      = '0;
        dec.data = tmds_decode8(sym);
        for (int i = 0; i < 4; i++) begin
            if (sym == CTRL_TOKEN[i]) begin
                dec.is_ctrl = 1'b1;
                dec.ctrl    = 2'(i);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (sym == TERC4_CODE[i]) begin
                dec.terc4_valid = 1'b1;
                dec.terc4       = 4'(i);
            end
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: finds the symbol boundary from control-token runs and decodes each symbol.
// Outputs registered, 1 cycle after the symbol's last bit (2 at offset 0); no backpressure.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT   = 16,
    parameter int SLIP_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT = 65536
) (
    input  logic           clk,
    input  logic           rst_n,
    tmds_decoder_if.slave  bus
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int TMO_W  = $clog2(SLIP_TIMEOUT + 1);
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

    logic [SYM_W-1:0]   prev_q;
    logic [2*SYM_W-1:0] cat;
    logic [SYM_W-1:0]   sym;
    tmds_sym_t          dec;

    tmds_align_state_t  state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic [3:0]         offset_q, offset_d;

    logic               de_q;
    logic [1:0]         ctrl_q;
    logic [7:0]         data_q;
    logic [3:0]         terc4_q;
    logic               terc4_valid_q;

    // Older word in the low half so bit 0 of the window is the earliest bit.
    assign cat = {bus.raw_i, prev_q};
    assign sym = SYM_W'(cat >> offset_q);

    tmds_symbol_decode u_sym_dec (
        .sym (sym),
        .dec (dec)
    );

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        tmo_d    = tmo_q;
        loss_d   = loss_q;
        offset_d = offset_q;
        case (state_q)
            SEARCH: begin
                run_d  = dec.is_ctrl ? run_q + 1'b1 : '0;
                loss_d = '0;
                // Lock takes priority over a slip due on the same cycle.
                if (dec.is_ctrl && (run_q == RUN_W'(LOCK_COUNT - 1))) begin
                    state_d = LOCKED;
                    run_d   = '0;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_W'(SLIP_TIMEOUT - 1)) begin
                    offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 1'b1;
                    run_d    = '0;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            LOCKED: begin
                if (dec.is_ctrl) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_W'(LOSS_TIMEOUT - 1)) begin
                    state_d = SEARCH;
                    run_d   = '0;
                    tmo_d   = '0;
                    loss_d  = '0;
                end else begin
                    loss_d = loss_q + 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            state_q  <= SEARCH;
            run_q    <= '0;
            tmo_q    <= '0;
            loss_q   <= '0;
            offset_q <= '0;
        end else begin
            prev_q   <= bus.raw_i;
            state_q  <= state_d;
            run_q    <= run_d;
            tmo_q    <= tmo_d;
            loss_q   <= loss_d;
            offset_q <= offset_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q          <= 1'b0;
            ctrl_q        <= '0;
            data_q        <= '0;
            terc4_q       <= '0;
            terc4_valid_q <= 1'b0;
        end else begin
            de_q          <= ~dec.is_ctrl;
            if (dec.is_ctrl) begin
                ctrl_q <= dec.ctrl;
            end
            data_q        <= dec.data;
            terc4_q       <= dec.terc4;
            terc4_valid_q <= dec.terc4_valid;
        end
    end

    assign bus.locked_o      = (state_q == LOCKED);
    assign bus.offset_o      = offset_q;
    assign bus.de_o          = de_q;
    assign bus.ctrl_o        = ctrl_q;
    assign bus.data_o        = data_q;
    assign bus.terc4_o       = terc4_q;
    assign bus.terc4_valid_o = terc4_valid_q;

endmodule
